// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit: op
// encodings, FSM state enumeration and the default datapath width.
package muldiv_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic [3:0] OP_MULT  = 4'h8;
  localparam logic [3:0] OP_MULTU = 4'h9;
  localparam logic [3:0] OP_DIV   = 4'hA;
  localparam logic [3:0] OP_DIVU  = 4'hB;
  localparam logic [3:0] OP_MFHI  = 4'hC;
  localparam logic [3:0] OP_MFLO  = 4'hD;
  localparam logic [3:0] OP_MTHI  = 4'hE;
  localparam logic [3:0] OP_MTLO  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath: operand capture with magnitude
// conversion, one shift-add or restoring-divide step per strobe, and the
// final sign correction presented as combinational HI/LO results.
// Optional build macro: MULDIV_EARLY_EXIT_EN (reports when the remaining
// multiplier bits are all zero so the FSM can cut the multiply short).
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_fix,
  input  logic              i_isDiv,
  input  logic              i_isSigned,
  input  logic [DATA_W-1:0] i_opA,
  input  logic [DATA_W-1:0] i_opB,
  output logic              o_mulLast,
  output logic [DATA_W-1:0] o_resHi,
  output logic [DATA_W-1:0] o_resLo
);

  // r_acc is the product accumulator for MUL and {remainder, quotient} for DIV.
  // r_shift holds the left-shifting multiplicand, or the divisor in its low half.
  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] r_shift;
  logic [DATA_W-1:0]   r_mplier;
  logic [DATA_W-1:0]   r_origA;
  logic                r_signA;
  logic                r_signB;
  logic                r_isDiv;
  logic                r_divZero;

  logic                w_negA;
  logic                w_negB;
  logic [DATA_W-1:0]   w_magA;
  logic [DATA_W-1:0]   w_magB;
  logic [2*DATA_W-1:0] w_mulAdd;
  logic [DATA_W:0]     w_remShift;
  logic                w_divFits;
  logic [DATA_W-1:0]   w_divDiff;
  logic [2*DATA_W-1:0] w_divNext;
  logic                w_signsDiffer;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;

  assign w_negA = i_isSigned & i_opA[DATA_W-1];
  assign w_negB = i_isSigned & i_opB[DATA_W-1];
  assign w_magA = w_negA ? -i_opA : i_opA;
  assign w_magB = w_negB ? -i_opB : i_opB;

  assign w_mulAdd = r_acc + r_shift;

  // The running remainder is always below the divisor, so the shifted value
  // fits in DATA_W+1 bits and the successful difference fits in DATA_W bits.
  assign w_remShift = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_divFits  = (w_remShift >= {1'b0, r_shift[DATA_W-1:0]});
  assign w_divDiff  = w_remShift[DATA_W-1:0] - r_shift[DATA_W-1:0];
  assign w_divNext  = w_divFits ? {w_divDiff, r_acc[DATA_W-2:0], 1'b1}
                                : {w_remShift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};

`ifdef MULDIV_EARLY_EXIT_EN
  assign o_mulLast = (r_mplier[DATA_W-1:1] == '0);
`else
  assign o_mulLast = 1'b0;
`endif

  // Capture operands on start, iterate on step, and clear working state once
  // the result has been committed to HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_shift   <= '0;
      r_mplier  <= '0;
      r_origA   <= '0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_isDiv   <= 1'b0;
      r_divZero <= 1'b0;
    end else if (i_start) begin
      r_origA   <= i_opA;
      r_signA   <= w_negA;
      r_signB   <= w_negB;
      r_isDiv   <= i_isDiv;
      r_divZero <= (i_opB == '0);
      if (i_isDiv) begin
        r_acc    <= {{DATA_W{1'b0}}, w_magA};
        r_shift  <= {{DATA_W{1'b0}}, w_magB};
        r_mplier <= '0;
      end else begin
        r_acc    <= '0;
        r_shift  <= {{DATA_W{1'b0}}, w_magA};
        r_mplier <= w_magB;
      end
    end else if (i_step) begin
      if (r_isDiv) begin
        r_acc <= w_divNext;
      end else begin
        if (r_mplier[0]) begin
          r_acc <= w_mulAdd;
        end
        r_shift  <= r_shift << 1;
        r_mplier <= r_mplier >> 1;
      end
    end else if (i_fix) begin
      r_acc    <= '0;
      r_shift  <= '0;
      r_mplier <= '0;
    end
  end

  assign w_signsDiffer = r_signA ^ r_signB;
  assign w_prod = w_signsDiffer ? -r_acc : r_acc;
  assign w_quo  = w_signsDiffer ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
  assign w_rem  = r_signA ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

  // Select the sign-corrected result; a zero divisor bypasses the iteration
  // result with all-ones quotient and the untouched dividend as remainder.
  always_comb begin
    o_resHi = w_prod[2*DATA_W-1:DATA_W];
    o_resLo = w_prod[DATA_W-1:0];
    if (r_isDiv) begin
      if (r_divZero) begin
        o_resHi = r_origA;
        o_resLo = '1;
      end else begin
        o_resHi = w_rem;
        o_resLo = w_quo;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: decodes the HI/LO op group, sequences the iterative
// multiply/divide datapath, owns HI/LO and stalls dependent HI/LO ops while
// the engine is running.
// Optional build macro: MULDIV_EARLY_EXIT_EN (multiply finishes as soon as
// no set multiplier bits remain).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        op_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mf_result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  muldiv_state_e     r_state;
  muldiv_state_e     w_stateNext;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic              w_isMulDiv;
  logic              w_inIdle;
  logic              w_lastIter;
  logic              w_start;
  logic              w_step;
  logic              w_fix;
  logic              w_mulLast;
  logic [DATA_W-1:0] w_resHi;
  logic [DATA_W-1:0] w_resLo;

  assign w_isMulDiv = (op_in[3:2] == 2'b10);
  assign w_inIdle   = (r_state == ST_IDLE);
  assign w_lastIter = (r_count == LAST_ITER);

  muldiv_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_step     (w_step),
    .i_fix      (w_fix),
    .i_isDiv    (op_in[1]),
    .i_isSigned (~op_in[0]),
    .i_opA      (rs_val),
    .i_opB      (rt_val),
    .o_mulLast  (w_mulLast),
    .o_resHi    (w_resHi),
    .o_resLo    (w_resLo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode plus datapath strobes, busy and the upstream stall.
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_in && w_isMulDiv) begin
          w_start     = 1'b1;
          w_stateNext = op_in[1] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        w_step = 1'b1;
        if (w_lastIter || w_mulLast) begin
          w_stateNext = ST_FIX;
        end
      end
      ST_DIV: begin
        w_step = 1'b1;
        if (w_lastIter) begin
          w_stateNext = ST_FIX;
        end
      end
      ST_FIX: begin
        w_fix       = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
    busy  = ~w_inIdle;
    stall = valid_in & ~w_inIdle & op_in[3];
  end

  // Iteration counter: cleared on start and after the fix-up cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_start || w_fix) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= r_count + 1'b1;
    end
  end

  // HI/LO: engine results land at the end of FIX; MT ops write only in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix) begin
      r_hi <= w_resHi;
      r_lo <= w_resLo;
    end else if (w_inIdle && valid_in) begin
      if (op_in == OP_MTHI) begin
        r_hi <= rs_val;
      end
      if (op_in == OP_MTLO) begin
        r_lo <= rs_val;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

  // Same-cycle HI/LO read path for MFHI/MFLO; zero for every other op.
  always_comb begin
    mf_result = '0;
    if (op_in == OP_MFHI) begin
      mf_result = r_hi;
    end else if (op_in == OP_MFLO) begin
      mf_result = r_lo;
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage consumer of the 4-bit op field delivered by the ID/EX op register.
- Decodes the HI/LO op group (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO) and runs an iterative multiply/divide engine.
- Owns the HI/LO architectural registers.
- Raises a stall to freeze IF/ID/EX when a dependent HI/LO op arrives while the engine is busy.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- op_in  input  4  op from ID/EX register.
- valid_in  input  1  EX holds a real (non-bubble) instruction.
- rs_val  input  DATA_W  operand A (dividend / multiplicand / MT source).
- rt_val  input  DATA_W  operand B (divisor / multiplier).
- stall  output  1  freeze upstream pipeline registers this cycle.
- busy  output  1  engine running.
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.
- mf_result  output  DATA_W  MFHI/MFLO read data to EX result mux.

Behaviour:
- Op encoding (package constants):
  - 4'h8 MULT, 4'h9 MULTU, 4'hA DIV, 4'hB DIVU.
  - 4'hC MFHI, 4'hD MFLO, 4'hE MTHI, 4'hF MTLO.
  - 4'h0-4'h7 are ALU ops; this block ignores them (no stall, no state change).
- Reset (async, any state including mid-operation): state=IDLE, busy=0, hi=0, lo=0, iteration counter=0, internal accumulators=0. stall is combinational and is 0 during reset.
- States: IDLE, MUL, DIV, FIX.
- Start: in IDLE with valid_in=1 and a muldiv op:
  - Capture operand magnitudes (signed ops take absolute value) and the sign flags.
  - Go to MUL or DIV; counter=0.
  - No stall; the instruction retires from EX.
- MUL: shift-add, one multiplier bit per cycle, DATA_W cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, DATA_W cycles, then FIX.
- FIX: 1 cycle. Apply sign correction:
  - product negated if signs differ;
  - quotient negated if signs differ;
  - remainder takes dividend sign.
  - Write hi/lo at the end of FIX, then go to IDLE.
- Total busy = DATA_W+1 cycles after the start edge. New hi/lo are visible in the first IDLE cycle.
- MULT/MULTU result: hi = upper DATA_W bits, lo = lower DATA_W bits.
- DIV/DIVU result: lo = quotient, hi = remainder.
- Divide by zero: lo = all ones, hi = rs_val (signed and unsigned). Full latency still applies.
- Signed overflow (-2^(W-1) / -1): lo = 0x8000_0000, hi = 0. Natural wrap, no trap.
- stall = valid_in & (busy | FIX state) & op_in in {8..F}. The stalled op is re-presented every cycle and accepted in the first IDLE cycle.
- MFHI/MFLO in IDLE: mf_result = hi/lo combinationally, same cycle.
- mf_result = 0 for all non-MF ops.
- MTHI/MTLO in IDLE: hi/lo <= rs_val at the clock edge.
- MF/MT ops in the same IDLE cycle as a completion cannot occur, since FIX is a busy state.
- valid_in=0 with any op: no effect.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIX the next cycle. Product is unchanged; latency becomes (index of highest set multiplier bit + 1) + 1 cycles, with a minimum of 2. A zero multiplier gives 1 MUL cycle + FIX. DIV is unaffected.
- Undefined: fixed DATA_W+1 latency for all ops.

Decomposition:
- Shared package muldiv_pkg: op encoding localparams (OP_MULT..OP_MTLO), state enumeration constants, DATA_W default.
- One natural sub-module: muldiv_datapath. It holds the accumulator/shift registers plus the add/subtract step and sign-fix logic, driven by start/step/fix strobes from the FSM in ex_muldiv_unit.

Test Plan:
- Reset mid-DIV (assert rst at cycle 10 of DIV) -> busy=0, hi=lo=0 immediately; next MFLO returns 0 with no stall.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> busy for 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MFLO issued 1 cycle after a MULT start -> stall=1 for exactly 33 cycles; on the first IDLE cycle stall=0 and mf_result equals the new lo. An ALU op (4'h3) during busy -> stall=0.
- With MULDIV_EARLY_EXIT_EN: MULTU rs=5, rt=3 -> busy 3 cycles, lo=15, hi=0. Without it: busy 33 cycles, same result.
